// File: rtl/fmap_seq_ctl_pkg.sv
// Shared layer codes, per-layer output geometry and lookup helpers for the fmap sequencer.
package fmap_seq_ctl_pkg;

  localparam int LAYER_ST_W  = 4;
  localparam int LAYER_IDX_W = 7;
  localparam int LAYER_PIX_W = 18;

  typedef enum logic [LAYER_ST_W-1:0] {
    IDLE    = 4'd0,
    PADDING = 4'd1,
    CONV1   = 4'd2,
    RES_1   = 4'd3,
    RES_2   = 4'd4,
    UP_1    = 4'd5,
    UP_2    = 4'd6,
    CONV2   = 4'd7,
    FINISH  = 4'd8
  } layer_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } seq_e;

  localparam int BASE_W  = 160;
  localparam int BASE_H  = 90;
  localparam int BASE_N  = 24;
  localparam int UP1_N   = 96;
  localparam int UP2_W   = 320;
  localparam int UP2_H   = 180;
  localparam int UP2_N   = 96;
  localparam int CONV2_W = 640;
  localparam int CONV2_H = 360;
  localparam int CONV2_N = 24;

  function automatic logic is_compute(input logic [LAYER_ST_W-1:0] st);
    return layer_e'(st) inside {CONV1, RES_1, RES_2, UP_1, UP_2, CONV2};
  endfunction

  // Products fold at elaboration, so this is a constant table rather than a multiplier.
  function automatic logic [LAYER_PIX_W-1:0] layer_last(input logic [LAYER_ST_W-1:0] st);
    case (layer_e'(st))
      CONV1, RES_1, RES_2, UP_1: return LAYER_PIX_W'(BASE_W * BASE_H - 1);
      UP_2:                      return LAYER_PIX_W'(UP2_W * UP2_H - 1);
      CONV2:                     return LAYER_PIX_W'(CONV2_W * CONV2_H - 1);
      default:                   return '0;
    endcase
  endfunction

  function automatic logic [LAYER_IDX_W-1:0] layer_nfmap(input logic [LAYER_ST_W-1:0] st);
    case (layer_e'(st))
      CONV1, RES_1, RES_2: return LAYER_IDX_W'(BASE_N);
      UP_1:                return LAYER_IDX_W'(UP1_N);
      UP_2:                return LAYER_IDX_W'(UP2_N);
      CONV2:               return LAYER_IDX_W'(CONV2_N);
      default:             return '0;
    endcase
  endfunction

endpackage

// File: rtl/fmap_seq_ctl_if.sv
// Layer-state input and fmap sequencing outputs shared with the row/column controller.
interface fmap_seq_ctl_if #(
  parameter int ST_W  = 4,
  parameter int IDX_W = 7
) ();
  logic [ST_W-1:0]  state;
  logic [IDX_W-1:0] fmap_idx;
  logic [IDX_W-1:0] fmap_idx_delay4;
  logic             fmap_end;
  logic             pix_valid;
  logic             layer_done;

  modport master (
    input  state,
    output fmap_idx, fmap_idx_delay4, fmap_end, pix_valid, layer_done
  );

  modport slave (
    output state,
    input  fmap_idx, fmap_idx_delay4, fmap_end, pix_valid, layer_done
  );
endinterface

// File: rtl/fmap_seq_ctl_idx_delay_line.sv
// Fixed-depth shift register that replays the fmap index DEPTH clocks late.
module idx_delay_line #(
  parameter int W     = 7,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] stage_q [DEPTH];

  // NOTE: the stages are a handful of flops, not RAM, so clearing them on reset is cheap and keeps the delayed index defined.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];
endmodule

// File: rtl/fmap_seq_ctl.sv
// Walks every output fmap of the active layer one pixel per clock and flags the layer end.
module fmap_seq_ctl
  import fmap_seq_ctl_pkg::*;
#(
  parameter int ST_W  = LAYER_ST_W,
  parameter int IDX_W = LAYER_IDX_W,
  parameter int PIX_W = LAYER_PIX_W,
  parameter int DLY   = 4
) (
  input  logic           clk,
  input  logic           rst,
  fmap_seq_ctl_if.master bus
);
  seq_e             fsm_q, fsm_d;
  logic [ST_W-1:0]  prev_state_q;
  logic [IDX_W-1:0] fmap_idx_q, fmap_idx_d;
  logic [PIX_W-1:0] pix_cnt_q, pix_cnt_d;
  logic             layer_done_q;
  logic             fmap_end;
  logic             state_chg;
  logic             compute;
  logic [PIX_W-1:0] last_pix;
  logic [IDX_W-1:0] n_fmap;

  assign state_chg = (bus.state != prev_state_q);
  assign compute   = is_compute(bus.state);
  assign last_pix  = PIX_W'(layer_last(bus.state));
  assign n_fmap    = IDX_W'(layer_nfmap(bus.state));

  // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    fsm_d      = fsm_q;
    fmap_idx_d = fmap_idx_q;
    pix_cnt_d  = pix_cnt_q;
    fmap_end   = 1'b0;
    unique case (fsm_q)
      S_IDLE: begin
        if (compute && state_chg) begin
          fsm_d      = S_RUN;
          fmap_idx_d = '0;
          pix_cnt_d  = '0;
        end
      end
      S_RUN: begin
        // A layer switch mid-run drops the current layer without any end pulse.
        if (state_chg) begin
          fsm_d      = compute ? S_RUN : S_IDLE;
          fmap_idx_d = '0;
          pix_cnt_d  = '0;
        end else if (pix_cnt_q == last_pix) begin
          pix_cnt_d = '0;
          if (fmap_idx_q == n_fmap - IDX_W'(1)) begin
            fmap_end   = 1'b1;
            fsm_d      = S_DONE;
            fmap_idx_d = n_fmap;
          end else begin
            fmap_idx_d = fmap_idx_q + IDX_W'(1);
          end
        end else begin
          pix_cnt_d = pix_cnt_q + PIX_W'(1);
        end
      end
      S_DONE: begin
        if (state_chg) begin
          fsm_d      = compute ? S_RUN : S_IDLE;
          fmap_idx_d = '0;
          pix_cnt_d  = '0;
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q        <= S_IDLE;
      prev_state_q <= ST_W'(IDLE);
      fmap_idx_q   <= '0;
      pix_cnt_q    <= '0;
      layer_done_q <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      prev_state_q <= bus.state;
      fmap_idx_q   <= fmap_idx_d;
      pix_cnt_q    <= pix_cnt_d;
      layer_done_q <= fmap_end;
    end
  end

  idx_delay_line #(
    .W     (IDX_W),
    .DEPTH (DLY)
  ) u_idx_delay (
    .clk (clk),
    .rst (rst),
    .d_i (fmap_idx_q),
    .q_o (bus.fmap_idx_delay4)
  );

  assign bus.fmap_idx   = fmap_idx_q;
  assign bus.fmap_end   = fmap_end;
  assign bus.pix_valid  = (fsm_q == S_RUN);
  assign bus.layer_done = layer_done_q;
endmodule

// File: tb/tb_fmap_seq_ctl.sv
// Directed bench for fmap_seq_ctl; long layers are shortened by preloading the pixel/fmap counters.
module tb_fmap_seq_ctl;
  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   end_cnt = 0;
  int   done_cnt = 0;
  int   e0, d0;
  logic [6:0]  pre_idx;
  logic [17:0] pre_pix;

  fmap_seq_ctl_if #(.ST_W(4), .IDX_W(7)) bus ();

  fmap_seq_ctl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.fmap_end)   end_cnt++;
    if (bus.layer_done) done_cnt++;
  end

  task tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Jump the running layer close to a boundary instead of streaming hundreds of thousands of pixels.
  task preload(input logic [6:0] idx, input logic [17:0] pix);
    pre_idx = idx;
    pre_pix = pix;
    force dut.fmap_idx_q = pre_idx;
    force dut.pix_cnt_q  = pre_pix;
    #1;
    release dut.fmap_idx_q;
    release dut.pix_cnt_q;
  endtask

  task chk(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task test_reset;
    rst = 1'b1;
    bus.state = 4'd0;
    #3;
    chk("reset fmap_idx", int'(bus.fmap_idx), 0);
    chk("reset delay4", int'(bus.fmap_idx_delay4), 0);
    chk("reset fmap_end", int'(bus.fmap_end), 0);
    chk("reset pix_valid", int'(bus.pix_valid), 0);
    chk("reset layer_done", int'(bus.layer_done), 0);
    tick(2);
    rst = 1'b0;
    tick(2);
    chk("idle pix_valid", int'(bus.pix_valid), 0);
    chk("idle fmap_idx", int'(bus.fmap_idx), 0);
  endtask

  task test_conv1;
    bus.state = 4'd2;
    tick(1);
    chk("conv1 start pix_valid", int'(bus.pix_valid), 1);
    chk("conv1 start idx", int'(bus.fmap_idx), 0);
    tick(14399);
    chk("conv1 idx before step", int'(bus.fmap_idx), 0);
    tick(1);
    chk("conv1 idx after 14400", int'(bus.fmap_idx), 1);
    tick(3);
    chk("conv1 delay4 at +3", int'(bus.fmap_idx_delay4), 0);
    tick(1);
    chk("conv1 delay4 at +4", int'(bus.fmap_idx_delay4), 1);
    e0 = end_cnt;
    d0 = done_cnt;
    preload(7'd23, 18'd14395);
    tick(3);
    chk("conv1 no early end", int'(bus.fmap_end), 0);
    tick(1);
    chk("conv1 fmap_end", int'(bus.fmap_end), 1);
    chk("conv1 end idx", int'(bus.fmap_idx), 23);
    chk("conv1 end no done", int'(bus.layer_done), 0);
    tick(1);
    chk("conv1 terminal idx", int'(bus.fmap_idx), 24);
    chk("conv1 layer_done", int'(bus.layer_done), 1);
    chk("conv1 done no end", int'(bus.fmap_end), 0);
    chk("conv1 done pix_valid", int'(bus.pix_valid), 0);
    tick(1);
    chk("conv1 done one cycle", int'(bus.layer_done), 0);
    chk("conv1 idx holds", int'(bus.fmap_idx), 24);
    chk("conv1 end pulses", end_cnt - e0, 1);
    chk("conv1 done pulses", done_cnt - d0, 1);
    tick(2);
    chk("conv1 delay4 lag", int'(bus.fmap_idx_delay4), 23);
    tick(1);
    chk("conv1 delay4 terminal", int'(bus.fmap_idx_delay4), 24);
  endtask

  task test_back_to_back;
    bus.state = 4'd3;
    tick(1);
    chk("res1 restart idx", int'(bus.fmap_idx), 0);
    chk("res1 pix_valid", int'(bus.pix_valid), 1);
    preload(7'd23, 18'd14398);
    tick(1);
    chk("res1 fmap_end", int'(bus.fmap_end), 1);
    tick(1);
    chk("res1 terminal idx", int'(bus.fmap_idx), 24);
    chk("res1 layer_done", int'(bus.layer_done), 1);
    tick(4);
    bus.state = 4'd4;
    tick(1);
    chk("res2 b2b idx", int'(bus.fmap_idx), 0);
    for (int k = 0; k < 4; k++) begin
      chk("b2b delay4 old", int'(bus.fmap_idx_delay4), 24);
      tick(1);
    end
    chk("b2b delay4 new", int'(bus.fmap_idx_delay4), 0);
  endtask

  task test_mid_layer_switch;
    bus.state = 4'd3;
    tick(1);
    chk("switch restart idx", int'(bus.fmap_idx), 0);
    preload(7'd7, 18'd50);
    tick(2);
    chk("switch preload idx", int'(bus.fmap_idx), 7);
    e0 = end_cnt;
    d0 = done_cnt;
    bus.state = 4'd4;
    tick(1);
    chk("switch idx cleared", int'(bus.fmap_idx), 0);
    chk("switch pix_valid", int'(bus.pix_valid), 1);
    tick(14399);
    chk("switch pix cleared", int'(bus.fmap_idx), 0);
    tick(1);
    chk("switch full fmap", int'(bus.fmap_idx), 1);
    chk("switch no end", end_cnt - e0, 0);
    chk("switch no done", done_cnt - d0, 0);
    bus.state = 4'd0;
    tick(1);
    chk("abandon to idle valid", int'(bus.pix_valid), 0);
    chk("abandon to idle idx", int'(bus.fmap_idx), 0);
  endtask

  task test_conv2_wrap;
    bus.state = 4'd7;
    tick(1);
    chk("conv2 start", int'(bus.pix_valid), 1);
    preload(7'd3, 18'd230397);
    tick(2);
    chk("conv2 last pix idx", int'(bus.fmap_idx), 3);
    chk("conv2 no end", int'(bus.fmap_end), 0);
    tick(1);
    chk("conv2 wrap idx", int'(bus.fmap_idx), 4);
    tick(100);
    chk("conv2 after wrap", int'(bus.fmap_idx), 4);
    chk("conv2 still valid", int'(bus.pix_valid), 1);
  endtask

  task test_up_layers;
    bus.state = 4'd6;
    tick(1);
    chk("up2 restart idx", int'(bus.fmap_idx), 0);
    preload(7'd10, 18'd57598);
    tick(1);
    chk("up2 before step", int'(bus.fmap_idx), 10);
    tick(1);
    chk("up2 step at 57600", int'(bus.fmap_idx), 11);
    e0 = end_cnt;
    preload(7'd95, 18'd57597);
    tick(2);
    chk("up2 fmap_end", int'(bus.fmap_end), 1);
    tick(1);
    chk("up2 terminal idx", int'(bus.fmap_idx), 96);
    chk("up2 layer_done", int'(bus.layer_done), 1);
    chk("up2 end pulses", end_cnt - e0, 1);
    bus.state = 4'd5;
    tick(1);
    chk("up1 restart idx", int'(bus.fmap_idx), 0);
    preload(7'd23, 18'd14398);
    tick(1);
    chk("up1 no end at 23", int'(bus.fmap_end), 0);
    tick(1);
    chk("up1 idx past 23", int'(bus.fmap_idx), 24);
    chk("up1 still valid", int'(bus.pix_valid), 1);
  endtask

  task test_reset_mid_run;
    bus.state = 4'd2;
    tick(1);
    preload(7'd5, 18'd100);
    tick(2);
    chk("rst preload idx", int'(bus.fmap_idx), 5);
    #2;
    rst = 1'b1;
    bus.state = 4'd0;
    #1;
    chk("async rst fmap_idx", int'(bus.fmap_idx), 0);
    chk("async rst delay4", int'(bus.fmap_idx_delay4), 0);
    chk("async rst pix_valid", int'(bus.pix_valid), 0);
    chk("async rst fmap_end", int'(bus.fmap_end), 0);
    chk("async rst layer_done", int'(bus.layer_done), 0);
    tick(2);
    rst = 1'b0;
    tick(3);
    chk("post rst idle", int'(bus.pix_valid), 0);
    bus.state = 4'd2;
    tick(1);
    chk("post rst restart", int'(bus.pix_valid), 1);
    chk("post rst idx", int'(bus.fmap_idx), 0);
  endtask

  initial begin
    test_reset();
    test_conv1();
    test_back_to_back();
    test_mid_layer_switch();
    test_conv2_wrap();
    test_up_layers();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
